// File: rtl/mem_reg.sv
// mem_reg: 16 x 32-bit register file with two combinational read ports and one write port.
// Optional write-through bypass on the read ports when MEM_REG_WRITE_FORWARD_EN is defined.
module mem_reg #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_allow,
   input  logic              wr_allow,
   input  logic [ADDR_W-1:0] Rd,
   input  logic [ADDR_W-1:0] Rs1,
   input  logic [ADDR_W-1:0] Rs2,
   input  logic [DATA_W-1:0] DI,
   output logic [DATA_W-1:0] D1,
   output logic [DATA_W-1:0] D2
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREG];

   // Reset takes priority, so a write presented during reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_allow) begin
         regs[Rd] <= DI;
      end
   end

`ifdef MEM_REG_WRITE_FORWARD_EN
   logic wr_live;
   logic fwd1;
   logic fwd2;

   // Only a write that will actually land on the next edge is forwarded.
   assign wr_live = wr_allow && rst_n;
   assign fwd1    = wr_live && (Rs1 == Rd);
   assign fwd2    = wr_live && (Rs2 == Rd);

   assign D1 = !rd_allow ? '0 : (fwd1 ? DI : regs[Rs1]);
   assign D2 = !rd_allow ? '0 : (fwd2 ? DI : regs[Rs2]);
`else
   assign D1 = rd_allow ? regs[Rs1] : '0;
   assign D2 = rd_allow ? regs[Rs2] : '0;
`endif

endmodule

// File: tb/tb_mem_reg.sv
// Self-checking bench for mem_reg: directed literal checks plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_mem_reg;

   logic        clk;
   logic        rst_n;
   logic        rd_allow;
   logic        wr_allow;
   logic [3:0]  Rd;
   logic [3:0]  Rs1;
   logic [3:0]  Rs2;
   logic [31:0] DI;
   logic [31:0] D1;
   logic [31:0] D2;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [16];
   logic        model_ok = 1'b0;

   mem_reg #(.DATA_W(32), .ADDR_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_allow (rd_allow),
      .wr_allow (wr_allow),
      .Rd       (Rd),
      .Rs1      (Rs1),
      .Rs2      (Rs2),
      .DI       (DI),
      .D1       (D1),
      .D2       (D2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an array updated by the write rule, reset clears everything.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) model[i] <= 32'h0;
         model_ok <= 1'b1;
      end else if (wr_allow) begin
         model[Rd] <= DI;
      end
   end

   function automatic logic [31:0] exp_read(input logic [3:0] a);
      if (!rd_allow) return 32'h0;
`ifdef MEM_REG_WRITE_FORWARD_EN
      if (wr_allow && rst_n && (a == Rd)) return DI;
`endif
      return model[a];
   endfunction

   always @(negedge clk) begin
      if (model_ok) begin
         check("model_d1", D1, exp_read(Rs1));
         check("model_d2", D2, exp_read(Rs2));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   logic [31:0] same_cycle_exp;

   initial begin
      rst_n = 1'b0; rd_allow = 1'b0; wr_allow = 1'b0;
      Rd = '0; Rs1 = '0; Rs2 = '0; DI = '0;
      tick();

      // Reset sweep
      rst_n = 1'b1; rd_allow = 1'b1;
      for (int a = 0; a < 16; a++) begin
         Rs1 = a[3:0];
         sample();
         check("reset_sweep", D1, 32'h0);
         tick();
      end

      // Write while reads gated
      rd_allow = 1'b0; wr_allow = 1'b1; Rd = 4'd0; DI = 32'h45; Rs1 = 4'd0; Rs2 = 4'd0;
      sample();
      check("gated_d1", D1, 32'h0);
      check("gated_d2", D2, 32'h0);
      tick();
      wr_allow = 1'b0;
      sample();
      check("gated_after_d1", D1, 32'h0);
      tick();
      rd_allow = 1'b1;
      sample();
      check("r0_readback", D1, 32'h45);
      tick();

      // Multi-write
      wr_allow = 1'b1;
      Rd = 4'd1; DI = 32'h33;  tick();
      Rd = 4'd4; DI = 32'h777; tick();
      Rd = 4'd7; DI = 32'h69;  tick();
      wr_allow = 1'b0; Rs1 = 4'd4; Rs2 = 4'd7;
      sample();
      check("multi_r4", D1, 32'h777);
      check("multi_r7", D2, 32'h69);
      tick();
      Rs1 = 4'd3;
      sample();
      check("never_written_r3", D1, 32'h0);
      tick();
      Rs1 = 4'd1; Rs2 = 4'd1;
      sample();
      check("same_addr_d1", D1, 32'h33);
      check("same_addr_d2", D2, 32'h33);
      tick();

      // Write disabled
      wr_allow = 1'b0; Rd = 4'd0; DI = 32'h0;
      tick();
      Rs1 = 4'd0;
      sample();
      check("wr_disabled_r0", D1, 32'h45);
      tick();

      // Read disable
      rd_allow = 1'b0; Rs1 = 4'd4; Rs2 = 4'd7;
      sample();
      check("rd_off_d1", D1, 32'h0);
      check("rd_off_d2", D2, 32'h0);
      tick();
      rd_allow = 1'b1;
      sample();
      check("rd_on_d1", D1, 32'h777);
      check("rd_on_d2", D2, 32'h69);
      tick();

      // Same-cycle read/write of R5
      Rd = 4'd5; Rs1 = 4'd5; DI = 32'hABCD; wr_allow = 1'b1;
`ifdef MEM_REG_WRITE_FORWARD_EN
      same_cycle_exp = 32'hABCD;
`else
      same_cycle_exp = 32'h0;
`endif
      sample();
      check("rw_before_edge", D1, same_cycle_exp);
      tick();
      wr_allow = 1'b0;
      sample();
      check("rw_after_edge", D1, 32'hABCD);
      tick();

      // Reset during a write
      rst_n = 1'b0; wr_allow = 1'b1; Rd = 4'd5; DI = 32'h1234;
      tick();
      rst_n = 1'b1; wr_allow = 1'b0; Rs1 = 4'd5; Rs2 = 4'd4;
      sample();
      check("reset_wins_r5", D1, 32'h0);
      check("reset_clears_r4", D2, 32'h0);
      tick();

      // Randomized traffic, checked by the per-cycle compare process
      for (int n = 0; n < 400; n++) begin
         rst_n    = ($urandom_range(0, 40) != 0);
         rd_allow = ($urandom_range(0, 5) != 0);
         wr_allow = $urandom_range(0, 1) == 1;
         Rd       = 4'($urandom_range(0, 15));
         Rs1      = ($urandom_range(0, 3) == 0) ? Rd : 4'($urandom_range(0, 15));
         Rs2      = ($urandom_range(0, 3) == 0) ? Rs1 : 4'($urandom_range(0, 15));
         DI       = $urandom;
         tick();
      end

      rst_n = 1'b1; wr_allow = 1'b0;
      sample();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
